halfband_dec_sym: RTL and testbench

Receive-side 2:1 halfband decimator, the mirror of the transmit halfband interpolators. It accepts a full-rate 1s17 stream on every sys_clk and produces one filtered 1s17 output per decimation strobe (sys_clk2_en). It sits ahead of the matched filter, bringing the upconverted/ADC-rate stream back down to the matched-filter sample rate. The filter is an 11-tap symmetric halfband with a pre-adder and a 3-stage pipeline.

---
 rtl/halfband_dec_sym_pkg.sv | 32 +++
 rtl/halfband_dec_sym_if.sv | 12 +
 rtl/halfband_dec_sym.sv | 70 +++++++
 tb/tb_halfband_dec_sym.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/halfband_dec_sym_pkg.sv
// Shared constants, coefficients and output rounding for the 2:1 halfband decimator.
package hb_dec_pkg;

  localparam int unsigned DW     = 18;
  localparam int unsigned CW     = 18;
  localparam int unsigned N_TAPS = 11;
  localparam int unsigned PW     = 19;
  localparam int unsigned MW     = 37;
  localparam int unsigned SW     = 39;
  localparam int unsigned NPAIR  = 3;
  localparam int unsigned CTR    = N_TAPS / 2;

  localparam logic signed [CW-1:0] C0 = 18'sd839;
  localparam logic signed [CW-1:0] C2 = -18'sd6488;
  localparam logic signed [CW-1:0] C4 = 18'sd38417;
  localparam logic signed [CW-1:0] C5 = 18'sd65536;

  // Coefficient for symmetric pair g, which combines taps 2g and N_TAPS-1-2g.
  localparam logic signed [CW-1:0] CPAIR [NPAIR] = '{C0, C2, C4};

  localparam logic signed [DW-1:0] YMAX = 18'sh1FFFF;
  localparam logic signed [DW-1:0] YMIN = 18'sh20000;

  function automatic logic signed [DW-1:0] sat_rnd_1s17(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + SW'(65536)) >>> 17;
    if (r > SW'(YMAX)) return YMAX;
    if (r < SW'(YMIN)) return YMIN;
    return DW'(r);
  endfunction

endpackage

// File: rtl/halfband_dec_sym_if.sv
// Sample stream bundle: full-rate input with decimation strobe, decimated output.
interface halfband_dec_sym_if;

  logic                             sys_clk2_en;
  logic signed [hb_dec_pkg::DW-1:0] x_in;
  logic signed [hb_dec_pkg::DW-1:0] y;
  logic                             y_valid;

  modport master (output sys_clk2_en, x_in, input y, y_valid);
  modport slave  (input sys_clk2_en, x_in, output y, y_valid);

endinterface

// File: rtl/halfband_dec_sym.sv
// 11-tap symmetric halfband 2:1 decimator: full-rate delay line, pre-add,
// multiply, sum and round/saturate stages, each advanced by its own valid tag.
module halfband_dec_sym
  import hb_dec_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  halfband_dec_sym_if.slave bus
);

  logic signed [DW-1:0] d_q [N_TAPS];
  logic signed [DW-1:0] pc_q;
  logic signed [MW-1:0] mc_q;
  logic signed [SW-1:0] s_q;
  logic signed [SW-1:0] s_d;
  logic signed [DW-1:0] y_q;
  logic [2:0]           tag_q;
  logic                 valid_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_TAPS; k++) d_q[k] <= '0;
    end else begin
      d_q[0] <= bus.x_in;
      for (int unsigned k = 1; k < N_TAPS; k++) d_q[k] <= d_q[k-1];
    end
  end

  // Stages load only when their tag is set, so y reflects exactly the strobed state.
  for (genvar g = 0; g < NPAIR; g++) begin : g_pair
    logic signed [PW-1:0] p_q;
    logic signed [MW-1:0] m_q;

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        p_q <= '0;
        m_q <= '0;
      end else begin
        if (bus.sys_clk2_en) p_q <= PW'(d_q[2*g]) + PW'(d_q[N_TAPS-1-2*g]);
        if (tag_q[0])        m_q <= MW'(p_q) * MW'(CPAIR[g]);
      end
    end
  end

  always_comb begin
    s_d = SW'(g_pair[0].m_q) + SW'(g_pair[1].m_q) + SW'(g_pair[2].m_q) + SW'(mc_q);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      mc_q    <= '0;
      s_q     <= '0;
      y_q     <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (bus.sys_clk2_en) pc_q <= d_q[CTR];
      if (tag_q[0])        mc_q <= MW'(pc_q) * MW'(C5);
      if (tag_q[1])        s_q  <= s_d;
      if (tag_q[2])        y_q  <= sat_rnd_1s17(s_q);
      tag_q   <= {tag_q[1:0], bus.sys_clk2_en};
      valid_q <= tag_q[2];
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = valid_q;

endmodule

// File: tb/tb_halfband_dec_sym.sv
// Self-checking bench for halfband_dec_sym: an 11-tap FIR model over the input
// history, a latency queue, and directed impulse/DC/saturation/reset scenarios.
module tb_halfband_dec_sym;

  logic sys_clk;
  logic reset;
  halfband_dec_sym_if bus();

  halfband_dec_sym dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct { longint due; longint val; } ev_t;

  int     coef [11] = '{839, 0, -6488, 0, 38417, 65536, 38417, 0, -6488, 0, 839};
  int     hist [$];
  ev_t    pend [$];
  longint edge_n    = 0;
  longint exp_y     = 0;
  logic   exp_valid = 1'b0;
  bit     chk_on    = 1'b0;
  longint dq [$];
  longint mq [$];
  longint dv_edges [$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint model_out();
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < 11; k++) begin
      int idx;
      idx = hist.size() - 1 - k;
      if (idx >= 0) s += longint'(coef[k]) * longint'(hist[idx]);
    end
    r = (s + 65536) >>> 17;
    if (r > 131071)  r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  task automatic model_clear();
    hist.delete();
    pend.delete();
    exp_y     = 0;
    exp_valid = 1'b0;
  endtask

  task automatic cycle(input logic en, input int x);
    @(negedge sys_clk);
    bus.sys_clk2_en = en;
    bus.x_in        = 18'(x);
    @(posedge sys_clk);
    edge_n++;
    if (reset) begin
      model_clear();
    end else begin
      exp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        exp_y     = pend[0].val;
        exp_valid = 1'b1;
        mq.push_back(exp_y);
        void'(pend.pop_front());
      end
      if (en) pend.push_back('{edge_n + 3, model_out()});
      hist.push_back(x);
    end
  endtask

  task automatic clear_caps();
    dq.delete();
    mq.delete();
    dv_edges.delete();
  endtask

  task automatic check_seq(input string nm, input int exp[$]);
    chk({nm, "_dut_count"}, dq.size(), exp.size());
    chk({nm, "_model_count"}, mq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dq.size()) chk($sformatf("%s_dut[%0d]", nm, i), dq[i], exp[i]);
      if (i < mq.size()) chk($sformatf("%s_model[%0d]", nm, i), mq[i], exp[i]);
    end
  endtask

  function automatic int rand_x();
    case ($urandom_range(7))
      0:       return 131071;
      1:       return -131072;
      default: return int'($urandom_range(262143)) - 131072;
    endcase
  endfunction

  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("y", bus.y, exp_y);
      chk("y_valid", longint'(bus.y_valid), longint'(exp_valid));
      if (bus.y_valid === 1'b1) begin
        dq.push_back(bus.y);
        dv_edges.push_back(edge_n);
      end
    end
  end

  initial begin
    int     sat_pat [11];
    int     nbefore;
    longint t_strobe;

    bus.sys_clk2_en = 1'b0;
    bus.x_in        = '0;
    reset           = 1'b0;
    #1 reset = 1'b1;
    #1 chk_on = 1'b1;
    model_clear();
    repeat (3) cycle(1'b0, 0);
    #2 reset = 1'b0;

    // Strobe never high: outputs stay idle.
    repeat (6) cycle(1'b0, 1000);
    repeat (12) cycle(1'b0, 0);

    clear_caps();
    for (int i = 0; i < 30; i++) cycle(1'(i % 2), (i == 12) ? 65536 : 0);
    repeat (4) cycle(1'b0, 0);
    check_seq("even", '{0, 0, 0, 0, 0, 0, 420, -3244, 19209, 19209, -3244, 420, 0, 0, 0});

    clear_caps();
    for (int i = 0; i < 30; i++) cycle(1'(i % 2), (i == 11) ? 65536 : 0);
    repeat (4) cycle(1'b0, 0);
    check_seq("odd", '{0, 0, 0, 0, 0, 0, 0, 0, 32768, 0, 0, 0, 0, 0, 0});

    clear_caps();
    for (int i = 0; i < 21; i++) cycle(1'b1, (i == 5) ? 65536 : 0);
    repeat (4) cycle(1'b0, 0);
    check_seq("cont", '{0, 0, 0, 0, 0, 0, 420, 0, -3244, 0, 19209, 32768, 19209,
                        0, -3244, 0, 420, 0, 0, 0, 0});
    if (dv_edges.size() == 21) chk("cont_span", dv_edges[20] - dv_edges[0], 20);

    clear_caps();
    for (int i = 0; i < 30; i++) cycle(1'(i % 2), 131071);
    repeat (4) cycle(1'b0, 131071);
    chk("dc_pos_dut",   (dq.size() > 0) ? dq[$] : -1, 131071);
    chk("dc_pos_model", (mq.size() > 0) ? mq[$] : -1, 131071);

    clear_caps();
    for (int i = 0; i < 30; i++) cycle(1'(i % 2), -131072);
    repeat (4) cycle(1'b0, -131072);
    chk("dc_neg_dut",   (dq.size() > 0) ? dq[$] : -1, -131072);
    chk("dc_neg_model", (mq.size() > 0) ? mq[$] : -1, -131072);

    // Worst-case sign-matched pattern drives the sum beyond full scale.
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 11; j++)
        sat_pat[j] = ((coef[j] < 0) != (s == 1)) ? -131072 : 131071;
      clear_caps();
      for (int j = 0; j < 11; j++) cycle(1'b0, sat_pat[j]);
      cycle(1'b1, 0);
      repeat (4) cycle(1'b0, 0);
      chk($sformatf("sat%0d_dut", s),   (dq.size() > 0) ? dq[$] : -1, (s == 0) ? 131071 : -131072);
      chk($sformatf("sat%0d_model", s), (mq.size() > 0) ? mq[$] : -1, (s == 0) ? 131071 : -131072);
    end

    for (int i = 0; i < 400; i++) cycle(1'($urandom_range(2) != 0), rand_x());

    // Asynchronous reset with results in flight.
    repeat (3) cycle(1'b1, rand_x());
    @(posedge sys_clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_y", bus.y, 0);
    chk("rst_async_valid", longint'(bus.y_valid), 0);
    model_clear();
    repeat (2) cycle(1'b0, 0);
    #2 reset = 1'b0;
    nbefore = dq.size();
    repeat (5) cycle(1'b0, rand_x());
    chk("rst_no_valid", dq.size() - nbefore, 0);

    for (int i = 0; i < 200; i++) cycle(1'($urandom_range(1)), rand_x());
    repeat (4) cycle(1'b0, rand_x());

    // Single strobe: one pulse three edges later, then y holds.
    repeat (12) cycle(1'b0, rand_x());
    clear_caps();
    cycle(1'b1, rand_x());
    t_strobe = edge_n;
    repeat (24) cycle(1'b0, rand_x());
    chk("single_pulse_count", dq.size(), 1);
    chk("single_latency", (dv_edges.size() > 0) ? dv_edges[0] - t_strobe : -1, 3);
    chk("single_hold_y", bus.y, (mq.size() > 0) ? mq[0] : -999999);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
